// File: rtl/cache_pkg.sv
// Shared cache constants and state encodings.
// Used by the fill FSM, the cache controller and the memory arbiter.
package cache_pkg;

   localparam int unsigned WORDS_PER_BLOCK   = 8;
   localparam int unsigned BLOCK_OFFSET_BITS = 4;
   localparam int unsigned WORD_IDX_BITS     = 3;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FILL = 1'b1
   } fill_state_e;

   // Byte offset of a 16-bit word inside a block: word index times two.
   function automatic logic [BLOCK_OFFSET_BITS-1:0] word_byte_offset(
      input logic [WORD_IDX_BITS-1:0] idx
   );
      return {idx, 1'b0};
   endfunction

endpackage

// File: rtl/cache_word_counter.sv
// Word-index counter for one side of a block fill.
// Counts 0..LAST while enabled; on the step past LAST it raises done and
// holds, so {done, cnt} never wraps back to zero mid-fill. clr has priority.
module cache_word_counter
   import cache_pkg::*;
#(
   parameter logic [WORD_IDX_BITS-1:0] LAST = 3'd7
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     en,
   output logic [WORD_IDX_BITS-1:0] cnt,
   output logic                     done
);

   // Count register with saturating done flag; synchronous clear wins over enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         done <= 1'b0;
      end else if (clr) begin
         cnt  <= '0;
         done <= 1'b0;
      end else if (en && !done) begin
         if (cnt == LAST) begin
            done <= 1'b1;
         end else begin
            cnt <= cnt + WORD_IDX_BITS'(1);
         end
      end else begin
         cnt  <= cnt;
         done <= done;
      end
   end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: fetches one block word by word from main memory
// and drives the data/tag array write strobes to install it.
// Optional build macro CACHE_FILL_PERF_CNT_EN adds a saturating fill_count
// output counting IDLE->FILL transitions.
module cache_fill_fsm #(
   parameter int unsigned WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK,
   parameter int unsigned ADDR_WIDTH      = 16
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                miss_detected,
   input  logic [ADDR_WIDTH-1:0]               miss_address,
   input  logic [15:0]                         memory_data,
   input  logic                                memory_data_valid,
   output logic                                fsm_busy,
   output logic                                memory_en,
   output logic [ADDR_WIDTH-1:0]               memory_address,
   output logic                                write_data_array,
   output logic                                write_tag_array,
   output logic [cache_pkg::WORD_IDX_BITS-1:0] word_num
`ifdef CACHE_FILL_PERF_CNT_EN
   ,
   output logic [15:0]                         fill_count
`endif
);

   import cache_pkg::*;

   localparam logic [WORD_IDX_BITS-1:0] LAST_IDX = WORD_IDX_BITS'(WORDS_PER_BLOCK - 1);

   fill_state_e                               state_r;
   logic [ADDR_WIDTH-1:BLOCK_OFFSET_BITS]     base_r;

   logic [WORD_IDX_BITS-1:0] issue_cnt_s;
   logic                     issue_done_s;
   logic [WORD_IDX_BITS-1:0] recv_cnt_s;
   logic                     recv_done_s;

   logic issue_fire_s;
   logic recv_fire_s;
   logic last_word_s;
   logic cnt_clr_s;
   logic unused_s;

   // The data path bypasses this block and the in-block offset is dropped on purpose.
   assign unused_s = ^{memory_data, miss_address[BLOCK_OFFSET_BITS-1:0]};

   // A request goes out every FILL cycle until all words are issued.
   assign issue_fire_s = (state_r == FILL) && !issue_done_s;
   // A return is only accepted in FILL and never beyond the last word.
   assign recv_fire_s  = (state_r == FILL) && memory_data_valid && !recv_done_s;
   assign last_word_s  = recv_fire_s && (recv_cnt_s == LAST_IDX);
   // Counters sit at zero in IDLE and are wiped as the final word lands.
   assign cnt_clr_s    = (state_r == IDLE) || last_word_s;

   cache_word_counter #(
      .LAST (LAST_IDX)
   ) issue_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr_s),
      .en   (issue_fire_s),
      .cnt  (issue_cnt_s),
      .done (issue_done_s)
   );

   cache_word_counter #(
      .LAST (LAST_IDX)
   ) recv_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr_s),
      .en   (recv_fire_s),
      .cnt  (recv_cnt_s),
      .done (recv_done_s)
   );

   // Fill FSM: latch the block base on a miss, return to IDLE after the last word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         base_r  <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (miss_detected) begin
                  base_r  <= miss_address[ADDR_WIDTH-1:BLOCK_OFFSET_BITS];
                  state_r <= FILL;
               end else begin
                  state_r <= IDLE;
               end
            end
            FILL: begin
               if (last_word_s) begin
                  state_r <= IDLE;
               end else begin
                  state_r <= FILL;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Outputs decoded from registered state/counters; write strobes follow memory valid.
   always_comb begin
      fsm_busy         = (state_r == FILL);
      memory_en        = issue_fire_s;
      memory_address   = '0;
      write_data_array = recv_fire_s;
      write_tag_array  = last_word_s;
      word_num         = '0;
      if (issue_fire_s) begin
         memory_address = {base_r, word_byte_offset(issue_cnt_s)};
      end else begin
         memory_address = '0;
      end
      if (recv_fire_s) begin
         word_num = recv_cnt_s;
      end else begin
         word_num = '0;
      end
   end

`ifdef CACHE_FILL_PERF_CNT_EN
   logic [15:0] fill_count_r;

   // Saturating count of fills started.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_count_r <= 16'd0;
      end else if ((state_r == IDLE) && miss_detected && (fill_count_r != 16'hFFFF)) begin
         fill_count_r <= fill_count_r + 16'd1;
      end else begin
         fill_count_r <= fill_count_r;
      end
   end

   assign fill_count = fill_count_r;
`endif

endmodule
